// File: rtl/csa_accum.sv
// csa_accum: multi-operand carry-save accumulator with a chunked resolve stage.
// Each accepted beat of NI operands is folded into a redundant (sum, carry)
// state through a tree of 4:2 compressors in a single cycle. The last beat of
// a group starts a CW-bit-per-cycle carry-propagate resolve. The binary result
// is then offered on a valid/ready port.
// Build option: define CSA_ACCUM_SIGNED_EN to treat operands as two's
// complement (sign extension). Leave it undefined for unsigned zero extension.
module csa_accum #(
    parameter int DW   = 8,
    parameter int NI   = 4,
    parameter int AW   = 16,
    parameter int CW   = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NI*DW-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        out_sum,
    output logic [CNTW-1:0]      out_beats
);

    localparam int NCH = AW / CW;
    // One spare code so the counter can mark the settle cycle after the last chunk.
    localparam int KW  = $clog2(NCH + 1);

    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_RES = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_acc_s;
    logic [AW-1:0]   r_acc_c;
    logic [CNTW-1:0] r_count;
    logic [KW-1:0]   r_k;
    logic            r_cy;
    logic [AW-1:0]   r_out_sum;

    logic [AW-1:0]   w_ext [NI];
    logic [2*AW-1:0] w_ops_red;
    logic [2*AW-1:0] w_acc_next;
    logic [CW:0]     w_chunk;
    logic            w_accept;

    // 4:2 compressor with cin=0. It is built from two chained 3:2 layers.
    // Each carry vector moves up one bit, and bits pushed past AW-1 are dropped.
    // The result is {carry, sum}, and carry + sum == a+b+c+d modulo 2^AW.
    function automatic logic [2*AW-1:0] compress42(
        input logic [AW-1:0] a,
        input logic [AW-1:0] b,
        input logic [AW-1:0] c,
        input logic [AW-1:0] d
    );
        logic [AW-1:0] s1, c1, s2, c2;
        s1 = a ^ b ^ c;
        c1 = ((a & b) | (a & c) | (b & c)) << 1;
        s2 = s1 ^ d ^ c1;
        c2 = ((s1 & d) | (s1 & c1) | (d & c1)) << 1;
        return {c2, s2};
    endfunction

    // Widen every operand to the accumulator width.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
`ifdef CSA_ACCUM_SIGNED_EN
            w_ext[i] = AW'($signed(in_data[i*DW +: DW]));
`else
            w_ext[i] = AW'(in_data[i*DW +: DW]);
`endif
        end
    end

    // Reduce the beat's operands to one redundant pair.
    generate
        if (NI == 8) begin : g_ni8
            logic [2*AW-1:0] w_lo;
            logic [2*AW-1:0] w_hi;
            assign w_lo      = compress42(w_ext[0], w_ext[1], w_ext[2], w_ext[3]);
            assign w_hi      = compress42(w_ext[4], w_ext[5], w_ext[6], w_ext[7]);
            assign w_ops_red = compress42(w_lo[AW-1:0], w_lo[2*AW-1:AW],
                                          w_hi[AW-1:0], w_hi[2*AW-1:AW]);
        end else begin : g_ni4
            assign w_ops_red = compress42(w_ext[0], w_ext[1], w_ext[2], w_ext[3]);
        end
    endgenerate

    // Fold the reduced beat into the running carry-save state.
    assign w_acc_next = compress42(w_ops_red[AW-1:0], w_ops_red[2*AW-1:AW],
                                   r_acc_s, r_acc_c);

    // The resolve consumes the low chunk of each redundant vector. Both vectors
    // shift right every cycle, so the current chunk is always at bit 0.
    assign w_chunk = (CW+1)'(r_acc_s[CW-1:0]) + (CW+1)'(r_acc_c[CW-1:0])
                   + (CW+1)'(r_cy);

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_OUT);
    assign out_sum   = r_out_sum;
    assign out_beats = r_count;
    // in_data feeds state only when a beat is accepted, so X on an idle bus stays out.
    assign w_accept  = in_valid && in_ready;

    // Control FSM, accumulation, and chunked carry-propagate resolve.
    // NOTE: all state here uses non-blocking assignments. Every register then
    // samples pre-edge values and the result does not depend on statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= ST_ACC;
            r_acc_s   <= '0;
            r_acc_c   <= '0;
            r_count   <= '0;
            r_k       <= '0;
            r_cy      <= 1'b0;
            r_out_sum <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc_s <= w_acc_next[AW-1:0];
                        r_acc_c <= w_acc_next[2*AW-1:AW];
                        if (r_count != {CNTW{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (in_last) begin
                            r_state <= ST_RES;
                            r_k     <= '0;
                            r_cy    <= 1'b0;
                        end
                    end
                end
                ST_RES: begin
                    if (r_k == KW'(NCH)) begin
                        // All chunks are resolved, and the final carry-out is discarded.
                        r_state <= ST_OUT;
                    end else begin
                        r_acc_s   <= r_acc_s >> CW;
                        r_acc_c   <= r_acc_c >> CW;
                        r_out_sum <= (r_out_sum >> CW)
                                   | (AW'(w_chunk[CW-1:0]) << (AW - CW));
                        r_cy      <= w_chunk[CW];
                        r_k       <= r_k + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_ACC;
                        r_acc_s <= '0;
                        r_acc_c <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum. Expected results come from a plain
// integer model: each operand is extended, the values are summed, and the sum
// is reduced modulo 2^16. The beat count saturates. Define
// CSA_ACCUM_SIGNED_EN here and in the RTL together.
module tb_csa_accum;

    logic        clk;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [15:0] out_beats;

    logic        n8_in_valid;
    logic        n8_in_ready;
    logic [63:0] n8_in_data;
    logic        n8_in_last;
    logic        n8_out_valid;
    logic        n8_out_ready;
    logic [15:0] n8_out_sum;
    logic [15:0] n8_out_beats;

    int n_tests = 0;
    int n_fail  = 0;

    csa_accum u_dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    csa_accum #(.NI(8)) u_dut8 (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (n8_in_valid),
        .in_ready  (n8_in_ready),
        .in_data   (n8_in_data),
        .in_last   (n8_in_last),
        .out_valid (n8_out_valid),
        .out_ready (n8_out_ready),
        .out_sum   (n8_out_sum),
        .out_beats (n8_out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ext_op(input logic [7:0] v);
        int x;
        x = int'(v);
`ifdef CSA_ACCUM_SIGNED_EN
        if (x >= 128) x = x - 256;
`endif
        return x;
    endfunction

    function automatic int beat_value(input logic [31:0] d);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += ext_op(d[i*8 +: 8]);
        return s;
    endfunction

    function automatic logic [15:0] mod16(input int v);
        return 16'(v);
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
    endtask

    task automatic end_beats();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 'x;
    endtask

    // Count edges until out_valid is high. Also note any cycle in which in_ready leaked high.
    task automatic wait_out(output int lat, output bit leak);
        lat  = 0;
        leak = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready !== 1'b0) leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nreset = 1'b0;
        #2;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL reset_out_sum: got %h want 0000", out_sum); end
        n_tests++; if (out_beats !== 16'h0) begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", out_beats); end
        @(posedge clk); #3;
        nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [31:0] d;
        int lat; bit leak;
        d = pack4(8'd1, 8'd2, 8'd3, 8'd4);
        send_beat(d, 1'b1);
        end_beats();
        wait_out(lat, leak);
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL single_latency: got %0d want 5", lat); end
        n_tests++; if (leak !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_res: in_ready high during resolve"); end
        n_tests++; if (out_sum !== mod16(beat_value(d))) begin n_fail++; $display("FAIL single_sum: got %h want %h", out_sum, mod16(beat_value(d))); end
        n_tests++; if (out_sum !== 16'd10) begin n_fail++; $display("FAIL single_sum_const: got %h want 000a", out_sum); end
        n_tests++; if (out_beats !== 16'd1) begin n_fail++; $display("FAIL single_beats: got %0d want 1", out_beats); end
        take_result();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int exp_acc; int lat; bit leak;
        d = pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        exp_acc = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_beat%0d: got %b want 1", i, in_ready); end
            send_beat(d, i == 3);
            exp_acc += beat_value(d);
        end
        end_beats();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after_last: got %b want 0", in_ready); end
        wait_out(lat, leak);
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        n_tests++; if (out_sum !== mod16(exp_acc)) begin n_fail++; $display("FAIL b2b_sum: got %h want %h", out_sum, mod16(exp_acc)); end
        n_tests++; if (out_beats !== 16'd4) begin n_fail++; $display("FAIL b2b_beats: got %0d want 4", out_beats); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_out: got %b want 0", in_ready); end
        take_result();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_hs: got %b want 1", in_ready); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int exp_acc; int lat; bit leak;
        d = pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        exp_acc = 0;
        for (int i = 0; i < 65; i++) begin
            send_beat(d, i == 64);
            exp_acc += beat_value(d);
        end
        end_beats();
        wait_out(lat, leak);
        n_tests++; if (out_sum !== mod16(exp_acc)) begin n_fail++; $display("FAIL wrap_sum: got %h want %h", out_sum, mod16(exp_acc)); end
        n_tests++; if (out_beats !== 16'd65) begin n_fail++; $display("FAIL wrap_beats: got %0d want 65", out_beats); end
        take_result();
    endtask

    task automatic test_ni8();
        int exp_acc; int lat;
        exp_acc = 0;
        n8_in_data = {8{8'hFF}};
        for (int i = 0; i < 33; i++) begin
            n8_in_valid = 1'b1;
            n8_in_last  = (i == 32);
            @(posedge clk); #1;
            for (int j = 0; j < 8; j++) exp_acc += ext_op(8'hFF);
        end
        n8_in_valid = 1'b0;
        n8_in_last  = 1'b0;
        lat = 0;
        while (n8_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL ni8_latency: got %0d want 5", lat); end
        n_tests++; if (n8_out_sum !== mod16(exp_acc)) begin n_fail++; $display("FAIL ni8_sum: got %h want %h", n8_out_sum, mod16(exp_acc)); end
        n_tests++; if (n8_out_beats !== 16'd33) begin n_fail++; $display("FAIL ni8_beats: got %0d want 33", n8_out_beats); end
        n8_out_ready = 1'b1;
        @(posedge clk); #1;
        n8_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [15:0] held;
        int lat; bit leak;
        d = pack4(8'd9, 8'd8, 8'd7, 8'd6);
        send_beat(d, 1'b1);
        end_beats();
        wait_out(lat, leak);
        held = mod16(beat_value(d));
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack4(8'd100, 8'd100, 8'd100, 8'd100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", i, out_valid); end
            n_tests++; if (out_sum !== held) begin n_fail++; $display("FAIL bp_sum_c%0d: got %h want %h", i, out_sum, held); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want 0", i, in_ready); end
        end
        end_beats();
        take_result();
        d = pack4(8'd5, 8'd0, 8'd0, 8'd0);
        send_beat(d, 1'b1);
        end_beats();
        wait_out(lat, leak);
        n_tests++; if (out_sum !== 16'd5) begin n_fail++; $display("FAIL bp_next_sum: got %h want 0005", out_sum); end
        n_tests++; if (out_beats !== 16'd1) begin n_fail++; $display("FAIL bp_next_beats: got %0d want 1", out_beats); end
        take_result();
    endtask

    task automatic test_signed();
        logic [31:0] d;
        int lat; bit leak;
        d = pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_beat(d, 1'b1);
        end_beats();
        wait_out(lat, leak);
`ifdef CSA_ACCUM_SIGNED_EN
        n_tests++; if (out_sum !== 16'hFFFC) begin n_fail++; $display("FAIL signed_sum: got %h want fffc", out_sum); end
`else
        n_tests++; if (out_sum !== 16'h03FC) begin n_fail++; $display("FAIL unsigned_sum: got %h want 03fc", out_sum); end
`endif
        take_result();
    endtask

    task automatic test_reset_mid_res();
        logic [31:0] d;
        int lat; bit leak;
        d = pack4(8'd200, 8'd150, 8'd99, 8'd3);
        send_beat(d, 1'b1);
        end_beats();
        @(posedge clk); #1;
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_res_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", out_valid); end
        n_tests++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL rst_res_sum: got %h want 0000", out_sum); end
        n_tests++; if (out_beats !== 16'h0) begin n_fail++; $display("FAIL rst_res_beats: got %0d want 0", out_beats); end
        @(posedge clk); #3;
        nreset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_no_partial: got %b want 0", out_valid); end
        d = pack4(8'd7, 8'd0, 8'd0, 8'd0);
        send_beat(d, 1'b1);
        end_beats();
        wait_out(lat, leak);
        n_tests++; if (out_sum !== 16'd7) begin n_fail++; $display("FAIL rst_res_after_sum: got %h want 0007", out_sum); end
        n_tests++; if (out_beats !== 16'd1) begin n_fail++; $display("FAIL rst_res_after_beats: got %0d want 1", out_beats); end
        take_result();
    endtask

    task automatic test_random();
        logic [31:0] d;
        int exp_acc; int n; int lat; bit leak;
        for (int g = 0; g < 20; g++) begin
            exp_acc = 0;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                // Idle cycles carry X data and a stray in_last, and neither may be absorbed.
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_last  = 1'b1;
                    in_data  = 'x;
                    @(posedge clk); #1;
                end
                d = $urandom;
                send_beat(d, i == n - 1);
                exp_acc += beat_value(d);
            end
            end_beats();
            wait_out(lat, leak);
            n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 5", g, lat); end
            n_tests++; if (out_sum !== mod16(exp_acc)) begin n_fail++; $display("FAIL rand%0d_sum: got %h want %h", g, out_sum, mod16(exp_acc)); end
            n_tests++; if (out_beats !== 16'(n)) begin n_fail++; $display("FAIL rand%0d_beats: got %0d want %0d", g, out_beats, n); end
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                @(posedge clk); #1;
            end
            take_result();
        end
    endtask

    initial begin
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        n8_in_valid  = 1'b0;
        n8_in_last   = 1'b0;
        n8_in_data   = '0;
        n8_out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_ni8();
        test_backpressure();
        test_signed();
        test_reset_mid_res();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
